// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the digit-serial add/subtract unit: state encoding,
// operation modes and the step-counter width helper.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_ADD = 1'b1;

  // A single-step operation still needs a 1-bit counter.
  function automatic int cntWidth(input int steps);
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_subtractor_digit_fs.sv
// Combinational DIGIT-bit ripple slice: a chain of per-bit full adder /
// full subtractor cells sharing one carry/borrow chain.
module digit_fs
  import serial_subtractor_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             mode,
  input  logic             cin,
  output logic [DIGIT-1:0] res,
  output logic             cout
);

  logic [DIGIT:0] chain;

  assign chain[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : gCell
    logic x;
    assign x      = a_dig[i] ^ b_dig[i];
    assign res[i] = x ^ chain[i];
    // Sum and difference bits are identical; only the chain term differs.
    assign chain[i+1] = (mode == MODE_ADD)
                        ? ((a_dig[i] & b_dig[i]) | (x & chain[i]))
                        : ((~a_dig[i] & b_dig[i]) | (~x & chain[i]));
  end

  assign cout = chain[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, LSD first, with a
// start/busy/done handshake and registered result, borrow/carry and zero flag.
//
//   state   | meaning
//   IDLE    | waiting for start; result outputs hold last completion
//   RUN     | one digit per edge through the slice
//   DONE    | one-cycle done pulse, then back to IDLE
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cntWidth(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH % DIGIT != 0) begin : gBadDigit
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic             modeR;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] sliceRes;
  logic             sliceCout;
  logic [WIDTH-1:0] accNext;

  digit_fs #(.DIGIT(DIGIT)) uSlice (
    .a_dig (aSh[DIGIT-1:0]),
    .b_dig (bSh[DIGIT-1:0]),
    .mode  (modeR),
    .cin   (br),
    .res   (sliceRes),
    .cout  (sliceCout)
  );

  // The partial result only needs to hold the digits already produced.
  if (DIGIT < WIDTH) begin : gAcc
    logic [WIDTH-DIGIT-1:0] acc;
    assign accNext = {sliceRes, acc};
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc <= '0;
      end else if (state == ST_RUN) begin
        acc <= accNext[WIDTH-1:DIGIT];
      end
    end
  end else begin : gNoAcc
    assign accNext = sliceRes;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      aSh   <= '0;
      bSh   <= '0;
      modeR <= MODE_SUB;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            aSh   <= a;
            bSh   <= b;
            modeR <= mode;
            br    <= bin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          aSh <= aSh >> DIGIT;
          bSh <= bSh >> DIGIT;
          br  <= sliceCout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            d     <= accNext;
            bout  <= sliceCout;
            zero  <= (accNext == '0);
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: four configurations of serial_subtractor checked
// against a whole-word arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  logic startV[4];
  logic modeV[4];
  logic binV[4];
  logic [15:0] aV[4];
  logic [15:0] bV[4];
  logic busyV[4];
  logic doneV[4];
  logic boutV[4];
  logic zeroV[4];
  logic [7:0]  d0, d1, d2;
  logic [15:0] d3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(startV[0]), .mode(modeV[0]), .a(aV[0][7:0]), .b(bV[0][7:0]),
    .bin(binV[0]), .busy(busyV[0]), .done(doneV[0]), .d(d0), .bout(boutV[0]), .zero(zeroV[0]));
  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u1 (
    .clk(clk), .rst(rst), .start(startV[1]), .mode(modeV[1]), .a(aV[1][7:0]), .b(bV[1][7:0]),
    .bin(binV[1]), .busy(busyV[1]), .done(doneV[1]), .d(d1), .bout(boutV[1]), .zero(zeroV[1]));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(startV[2]), .mode(modeV[2]), .a(aV[2][7:0]), .b(bV[2][7:0]),
    .bin(binV[2]), .busy(busyV[2]), .done(doneV[2]), .d(d2), .bout(boutV[2]), .zero(zeroV[2]));
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u3 (
    .clk(clk), .rst(rst), .start(startV[3]), .mode(modeV[3]), .a(aV[3]), .b(bV[3]),
    .bin(binV[3]), .busy(busyV[3]), .done(doneV[3]), .d(d3), .bout(boutV[3]), .zero(zeroV[3]));

  function automatic logic [15:0] getD(input int u);
    case (u)
      0:       return {8'h00, d0};
      1:       return {8'h00, d1};
      2:       return {8'h00, d2};
      default: return d3;
    endcase
  endfunction

  function automatic int widthOf(input int u);
    return (u == 3) ? 16 : 8;
  endfunction

  function automatic int stepsOf(input int u);
    case (u)
      0:       return 8;
      1:       return 4;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  // Whole-word reference: result modulo 2^w, borrow = a < b+bin, carry = overflow bit.
  function automatic void model(input int w, input bit m, input logic [15:0] av, input logic [15:0] bv,
                                input bit bi, output logic [15:0] dd, output bit bo);
    longint la, lb, s, mask;
    la   = longint'(av);
    lb   = longint'(bv);
    mask = (longint'(1) << w) - 1;
    if (m) begin
      s  = la + lb + longint'(bi);
      bo = ((s >> w) & 1) != 0;
    end else begin
      s  = la - lb - longint'(bi);
      bo = la < (lb + longint'(bi));
    end
    dd = 16'(s & mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic runOp(input int u, input bit m, input logic [15:0] av, input logic [15:0] bv,
                       input bit bi, input bit glitch, input string tag);
    int k;
    int steps;
    bit seenDone;
    logic [15:0] expD;
    logic [15:0] prevD;
    bit expB;
    steps = stepsOf(u);
    model(widthOf(u), m, av, bv, bi, expD, expB);
    prevD = getD(u);
    modeV[u]  = m;
    aV[u]     = av;
    bV[u]     = bv;
    binV[u]   = bi;
    startV[u] = 1'b1;
    step();
    startV[u] = 1'b0;
    check({tag, "/busy_run"}, 32'(busyV[u]), 32'd1);
    seenDone = 1'b0;
    for (k = 1; k <= steps + 4; k++) begin
      // Inputs churn while busy; a start here must be ignored.
      startV[u] = glitch && (k == 1);
      aV[u]     = (glitch && k == 1) ? 16'hFFFF : 16'($urandom);
      bV[u]     = 16'($urandom);
      modeV[u]  = 1'($urandom);
      binV[u]   = 1'($urandom);
      step();
      if (doneV[u]) begin
        seenDone = 1'b1;
        break;
      end
      if (k == 1) check({tag, "/d_hold_run"}, 32'(getD(u)), 32'(prevD));
    end
    startV[u] = 1'b0;
    check({tag, "/latency"}, seenDone ? 32'(k) : 32'hFFFF_FFFF, 32'(steps));
    check({tag, "/d"}, 32'(getD(u)), 32'(expD));
    check({tag, "/bout"}, 32'(boutV[u]), 32'(expB));
    check({tag, "/zero"}, 32'(zeroV[u]), 32'(expD == 16'h0));
    step();
    check({tag, "/busy_after"}, 32'(busyV[u]), 32'd0);
    check({tag, "/done_after"}, 32'(doneV[u]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int doneCount;
    logic [15:0] mask;
    rst = 1'b1;
    for (int u = 0; u < 4; u++) begin
      startV[u] = 1'b0;
      modeV[u]  = 1'b0;
      binV[u]   = 1'b0;
      aV[u]     = 16'h0;
      bV[u]     = 16'h0;
    end
    step();
    step();
    for (int u = 0; u < 4; u++) begin
      check($sformatf("reset%0d/busy", u), 32'(busyV[u]), 32'd0);
      check($sformatf("reset%0d/done", u), 32'(doneV[u]), 32'd0);
      check($sformatf("reset%0d/d", u), 32'(getD(u)), 32'd0);
      check($sformatf("reset%0d/bout", u), 32'(boutV[u]), 32'd0);
      check($sformatf("reset%0d/zero", u), 32'(zeroV[u]), 32'd0);
    end
    rst = 1'b0;
    step();

    runOp(0, 1'b0, 16'h5A, 16'h3C, 1'b0, 1'b0, "sub_5a_3c");
    check("sub_5a_3c/d_const", 32'(getD(0)), 32'h1E);

    // Async reset in the middle of a run.
    modeV[0] = 1'b0; aV[0] = 16'h33; bV[0] = 16'h11; binV[0] = 1'b0; startV[0] = 1'b1;
    step();
    startV[0] = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("midrst/busy", 32'(busyV[0]), 32'd0);
    check("midrst/d", 32'(getD(0)), 32'd0);
    check("midrst/bout", 32'(boutV[0]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (doneV[0]) doneCount++;
    end
    check("midrst/no_done", 32'(doneCount), 32'd0);
    runOp(0, 1'b0, 16'h33, 16'h11, 1'b0, 1'b0, "sub_33_11");
    check("sub_33_11/d_const", 32'(getD(0)), 32'h22);

    runOp(0, 1'b0, 16'h00, 16'h01, 1'b0, 1'b0, "sub_00_01");
    check("sub_00_01/d_const", 32'(getD(0)), 32'hFF);
    runOp(0, 1'b0, 16'h10, 16'h0F, 1'b1, 1'b0, "sub_10_0f_b");

    runOp(1, 1'b1, 16'hF0, 16'h20, 1'b1, 1'b0, "add_f0_20_c");
    check("add_f0_20_c/d_const", 32'(getD(1)), 32'h11);

    runOp(2, 1'b0, 16'h80, 16'h80, 1'b0, 1'b1, "sub_80_80_ign");
    check("sub_80_80_ign/zero_const", 32'(zeroV[2]), 32'd1);

    runOp(3, 1'b0, 16'h1234, 16'h1235, 1'b0, 1'b0, "sub16_1234_1235");
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("hold16/d%0d", i), 32'(getD(3)), 32'hFFFF);
    end

    for (int u = 0; u < 4; u++) begin
      mask = (widthOf(u) == 16) ? 16'hFFFF : 16'h00FF;
      for (int n = 0; n < 6; n++) begin
        runOp(u, 1'($urandom), 16'($urandom) & mask, 16'($urandom) & mask, 1'($urandom), 1'b0,
              $sformatf("rand_u%0d_n%0d", u, n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
